// File: rtl/naes_pkg.sv
// Shared definitions for the NES-style CPU/PPU glue: DMA FSM states and default bus addresses.
// Combinational-free; consumed by oam_dma.
package naes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_t;

    localparam logic [15:0] DMA_REG_DEFAULT  = 16'h4014;
    localparam logic [15:0] OAM_DATA_DEFAULT = 16'h2004;

    function automatic logic [15:0] page_addr(input logic [7:0] page, input logic [7:0] idx);
        return {page, idx};
    endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write of a page number to DMA_REG steals the bus and copies 256 bytes to OAM_DATA.
// Hijack lasts 513 cycles (514 when halted on an odd cycle); the CPU has no way to stall it.
module oam_dma
    import naes_pkg::*;
#(
    parameter logic [15:0] DMA_REG  = DMA_REG_DEFAULT,
    parameter logic [15:0] OAM_DATA = OAM_DATA_DEFAULT
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_din,
    input  logic        bus_wr,
    input  logic        odd_or_even,
    input  logic [7:0]  mem_din,
    output logic        dma_hijack,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_dout,
    output logic        dma_wr,
    output logic        dma_done
);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        data_d     = data_q;
        done_d     = 1'b0;
        dma_hijack = 1'b1;
        dma_addr   = page_addr(page_q, 8'h00);
        dma_wr     = 1'b1;
        dma_dout   = 8'h00;

        case (state_q)
            ST_IDLE: begin
                dma_hijack = 1'b0;
                if (bus_addr == DMA_REG && !bus_wr) begin
                    page_d  = bus_din;
                    idx_d   = 8'h00;
                    state_d = ST_HALT;
                end
            end
            // An odd-cycle halt needs one extra cycle so reads land on the CPU's get cycle.
            ST_HALT:  state_d = odd_or_even ? ST_ALIGN : ST_READ;
            ST_ALIGN: state_d = ST_READ;
            ST_READ: begin
                dma_addr = page_addr(page_q, idx_q);
                data_d   = mem_din;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                dma_addr = OAM_DATA;
                dma_wr   = 1'b0;
                dma_dout = data_q;
                if (idx_q == 8'hFF) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dma_done = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a byte-addressed memory model answers reads, a monitor counts bus activity.
module tb_oam_dma;

    logic        cpu_clk;
    logic        reset;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din;
    logic        bus_wr;
    logic        odd_or_even;
    logic [7:0]  mem_din;
    logic        dma_hijack;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_wr;
    logic        dma_done;

    int total = 0;
    int bad   = 0;
    int hij_cnt  = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;
    logic [7:0] key;

    oam_dma dut (
        .cpu_clk     (cpu_clk),
        .reset       (reset),
        .bus_addr    (bus_addr),
        .bus_din     (bus_din),
        .bus_wr      (bus_wr),
        .odd_or_even (odd_or_even),
        .mem_din     (mem_din),
        .dma_hijack  (dma_hijack),
        .dma_addr    (dma_addr),
        .dma_dout    (dma_dout),
        .dma_wr      (dma_wr),
        .dma_done    (dma_done)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    // Memory content: low address byte scrambled by a per-test key.
    assign mem_din = dma_addr[7:0] ^ key;

    always @(negedge cpu_clk) begin
        if (dma_hijack) hij_cnt <= hij_cnt + 1;
        if (dma_done) done_cnt <= done_cnt + 1;
        if (dma_hijack && !dma_wr && dma_addr == 16'h2004) wr_cnt <= wr_cnt + 1;
    end

    function automatic logic [31:0] obs_vec();
        return {5'b0, dma_hijack, dma_addr, dma_wr, dma_dout, dma_done};
    endfunction

    function automatic logic [31:0] ev(input logic h, input logic [15:0] a, input logic w,
                                       input logic [7:0] d, input logic dn);
        return {5'b0, h, a, w, d, dn};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // Starts a transfer at the current cycle (so it may be the dma_done cycle) and
    // returns in the dma_done cycle, or right after reset when aborted.
    task automatic run_xfer(input logic [7:0] pg, input bit odd, input logic [7:0] k,
                            input int retrig_at, input int abort_at);
        key = k;
        bus_addr = 16'h4014;
        bus_wr   = 1'b0;
        bus_din  = pg;
        tick();
        bus_addr = 16'h0000;
        bus_wr   = 1'b1;
        bus_din  = 8'h00;
        odd_or_even = odd;
        chk("halt", obs_vec(), ev(1'b1, {pg, 8'h00}, 1'b1, 8'h00, 1'b0));
        tick();
        odd_or_even = 1'b0;
        if (odd) begin
            chk("align", obs_vec(), ev(1'b1, {pg, 8'h00}, 1'b1, 8'h00, 1'b0));
            tick();
        end
        for (int i = 0; i < 256; i++) begin
            chk("read", obs_vec(), ev(1'b1, {pg, i[7:0]}, 1'b1, 8'h00, 1'b0));
            if (i == retrig_at) begin
                bus_addr = 16'h4014;
                bus_wr   = 1'b0;
                bus_din  = 8'h33;
            end
            tick();
            bus_addr = 16'h0000;
            bus_wr   = 1'b1;
            bus_din  = 8'h00;
            chk("write", obs_vec(), ev(1'b1, 16'h2004, 1'b0, i[7:0] ^ k, 1'b0));
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_async", obs_vec(), ev(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));
                return;
            end
            tick();
        end
        chk("done", obs_vec(), ev(1'b0, {pg, 8'h00}, 1'b1, 8'h00, 1'b1));
    endtask

    int h0, d0, w0;

    initial begin
        key         = 8'h00;
        reset       = 1'b1;
        bus_addr    = 16'h0000;
        bus_din     = 8'h00;
        bus_wr      = 1'b1;
        odd_or_even = 1'b0;
        #2;
        chk("reset_outputs", obs_vec(), ev(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_after_reset", obs_vec(), ev(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));

        // Near-miss accesses must not start a transfer.
        bus_addr = 16'h4014; bus_wr = 1'b1; bus_din = 8'h09;
        tick();
        chk("read_4014_no_trig", {31'b0, dma_hijack}, 32'd0);
        bus_addr = 16'h4015; bus_wr = 1'b0;
        tick();
        chk("write_4015_no_trig", {31'b0, dma_hijack}, 32'd0);
        bus_addr = 16'h0000; bus_wr = 1'b1; bus_din = 8'h00;
        tick();

        // Even parity, identity memory.
        h0 = hij_cnt; d0 = done_cnt; w0 = wr_cnt;
        run_xfer(8'h02, 1'b0, 8'h00, -1, -1);
        chk("even_hijack_len", hij_cnt - h0, 32'd513);
        tick();
        chk("done_pulse_1cyc", {31'b0, dma_done}, 32'd0);
        chk("even_done_count", done_cnt - d0, 32'd1);
        chk("even_write_count", wr_cnt - w0, 32'd256);

        // Odd parity, then a second trigger in its dma_done cycle.
        h0 = hij_cnt;
        run_xfer(8'h02, 1'b1, 8'h00, -1, -1);
        chk("odd_hijack_len", hij_cnt - h0, 32'd514);
        h0 = hij_cnt; d0 = done_cnt; w0 = wr_cnt;
        run_xfer(8'h11, 1'b0, 8'hA5, 50, -1);
        chk("b2b_hijack_len", hij_cnt - h0, 32'd513);
        tick();
        chk("b2b_write_count", wr_cnt - w0, 32'd256);
        chk("b2b_done_count", done_cnt - d0, 32'd2);
        tick();

        // Reset during the 100th write.
        d0 = done_cnt; w0 = wr_cnt;
        run_xfer(8'h05, 1'b0, 8'h00, -1, 99);
        tick();
        chk("abort_held", obs_vec(), ev(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));
        tick();
        reset = 1'b0;
        tick();
        chk("abort_idle", obs_vec(), ev(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0));
        tick();
        chk("abort_no_done", done_cnt - d0, 32'd0);
        chk("abort_write_count", wr_cnt - w0, 32'd99);

        // Clean restart from page 7.
        h0 = hij_cnt; w0 = wr_cnt;
        run_xfer(8'h07, 1'b0, 8'h3C, -1, -1);
        chk("restart_hijack_len", hij_cnt - h0, 32'd513);
        tick();
        chk("restart_write_count", wr_cnt - w0, 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
